// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous position controller for the square overlay: button sync/debounce,
// frame-end edge detection, and a per-frame move FSM with acceleration and edge clamping.
module sprite_motion_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPRITE_SIZE     = 75,
  parameter int INIT_X          = 240,
  parameter int INIT_Y          = 200,
  parameter int MAX_SPEED       = 4,
  parameter int ACCEL_FRAMES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       screenEnd,
  output logic [9:0] sq_x,
  output logic [8:0] sq_y,
  output logic [2:0] speed,
  output logic       moving,
  output logic       frame_tick
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (ACCEL_FRAMES > 2) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_FRAMES - 1);
  localparam logic [2:0]        MAX_SP    = 3'(MAX_SPEED);
  localparam logic signed [10:0] X_MAX_S  = 11'(SCREEN_W - SPRITE_SIZE);
  localparam logic signed [10:0] Y_MAX_S  = 11'(SCREEN_H - SPRITE_SIZE);

  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_U, DIR_D} dir_t;
  typedef enum logic {IDLE, MOVE} state_t;

  // Button bit order: 3=down, 2=up, 1=right, 0=left
  logic [3:0]            btn_meta_r, btn_sync_r, btn_db_r;
  logic [3:0][DB_W-1:0]  db_cnt_r;
  logic                  se_meta_r, se_sync_r, se_prev_r;

  state_t                state_r, state_n;
  dir_t                  dir_r, dir_n, dir_req_s;
  logic [HOLD_W-1:0]     hold_r, hold_n, hold_inc_s;
  logic [2:0]            speed_n;
  logic                  any_btn_s, do_step_s;
  logic signed [10:0]    x_calc_s, y_calc_s, delta_s, x_cl_s, y_cl_s;
  logic [9:0]            x_n;
  logic [8:0]            y_n;

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] hi);
    logic signed [10:0] r;
    if (v < 11'sd0) r = 11'sd0;
    else if (v > hi) r = hi;
    else r = v;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_r <= 4'b0000;
      btn_sync_r <= 4'b0000;
      se_meta_r  <= 1'b0;
      se_sync_r  <= 1'b0;
      se_prev_r  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      btn_meta_r <= {BTND, BTNU, BTNR, BTNL};
      btn_sync_r <= btn_meta_r;
      se_meta_r  <= screenEnd;
      se_sync_r  <= se_meta_r;
      se_prev_r  <= se_sync_r;
      frame_tick <= se_sync_r & ~se_prev_r;
    end
  end

  // A button's debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db_r <= 4'b0000;
      db_cnt_r <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_sync_r[i] == btn_db_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          btn_db_r[i] <= ~btn_db_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_btn_s = |btn_db_r;
    if (btn_db_r[3])      dir_req_s = DIR_D;
    else if (btn_db_r[2]) dir_req_s = DIR_U;
    else if (btn_db_r[1]) dir_req_s = DIR_R;
    else                  dir_req_s = DIR_L;
  end

  always_comb begin
    state_n    = state_r;
    dir_n      = dir_r;
    speed_n    = speed;
    hold_n     = hold_r;
    do_step_s  = 1'b0;
    hold_inc_s = hold_r + 1'b1;
    if (frame_tick) begin
      case (state_r)
        IDLE: begin
          speed_n = 3'd1;
          hold_n  = '0;
          if (any_btn_s) begin
            state_n   = MOVE;
            dir_n     = dir_req_s;
            do_step_s = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        MOVE: begin
          if (!any_btn_s) begin
            state_n = IDLE;
            speed_n = 3'd1;
            hold_n  = '0;
          end else if (dir_req_s != dir_r) begin
            dir_n     = dir_req_s;
            speed_n   = 3'd1;
            hold_n    = '0;
            do_step_s = 1'b1;
          end else begin
            do_step_s = 1'b1;
            // The step on the accelerating frame already uses the raised speed
            if (hold_inc_s == HOLD_LAST) begin
              hold_n  = '0;
              speed_n = (speed < MAX_SP) ? speed + 3'd1 : speed;
            end else begin
              hold_n = hold_inc_s;
            end
          end
        end
        default: begin
          state_n = IDLE;
          speed_n = 3'd1;
          hold_n  = '0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  always_comb begin
    x_calc_s = {1'b0, sq_x};
    y_calc_s = {2'b00, sq_y};
    delta_s  = {8'b0, speed_n};
    if (do_step_s) begin
      case (dir_n)
        DIR_D:   y_calc_s = y_calc_s + delta_s;
        DIR_U:   y_calc_s = y_calc_s - delta_s;
        DIR_R:   x_calc_s = x_calc_s + delta_s;
        DIR_L:   x_calc_s = x_calc_s - delta_s;
        default: x_calc_s = x_calc_s;
      endcase
    end else begin
      x_calc_s = x_calc_s;
    end
    x_cl_s = clamp(x_calc_s, X_MAX_S);
    y_cl_s = clamp(y_calc_s, Y_MAX_S);
    x_n    = x_cl_s[9:0];
    y_n    = y_cl_s[8:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      dir_r   <= DIR_L;
      hold_r  <= '0;
      sq_x    <= 10'(INIT_X);
      sq_y    <= 9'(INIT_Y);
      speed   <= 3'd1;
      moving  <= 1'b0;
    end else begin
      state_r <= state_n;
      dir_r   <= dir_n;
      hold_r  <= hold_n;
      sq_x    <= x_n;
      sq_y    <= y_n;
      speed   <= speed_n;
      moving  <= (state_n == MOVE);
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: directed frame table, corner-case
// sequences and randomized frames checked against an arithmetic position model.
module tb_sprite_motion_ctrl;
  localparam int DB = 4, ACC = 4, MAXSP = 4, XMAX = 565, YMAX = 405;

  logic       clk = 1'b0;
  logic       reset, BTNU, BTND, BTNL, BTNR, screenEnd;
  logic [9:0] sq_x;
  logic [8:0] sq_y;
  logic [2:0] speed;
  logic       moving, frame_tick;

  sprite_motion_ctrl #(.DEBOUNCE_CYCLES(DB), .ACCEL_FRAMES(ACC)) dut (
    .clk(clk), .reset(reset), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .screenEnd(screenEnd), .sq_x(sq_x), .sq_y(sq_y), .speed(speed),
    .moving(moving), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, frames_sent = 0;
  int tick_count = 0;
  bit double_tick = 1'b0, prev_tick = 1'b0;

  always @(negedge clk) begin
    if (frame_tick) begin
      tick_count <= tick_count + 1;
      if (prev_tick) double_tick <= 1'b1;
    end
    prev_tick <= frame_tick;
  end

  // Reference model: speed follows the length of the current same-direction run
  int m_x, m_y, m_speed, m_moving, m_dir, m_run;

  task automatic model_reset();
    m_x = 240; m_y = 200; m_speed = 1; m_moving = 0; m_dir = 0; m_run = 0;
  endtask

  task automatic model_frame(input logic [3:0] b);
    int d;
    if (b == 4'b0000) begin
      m_moving = 0; m_speed = 1; m_run = 0;
    end else begin
      d = b[3] ? 3 : (b[2] ? 2 : (b[1] ? 1 : 0));
      if (m_moving != 0 && d == m_dir) m_run = m_run + 1;
      else m_run = 1;
      m_dir = d; m_moving = 1;
      m_speed = 1 + (m_run - 1) / (ACC - 1);
      if (m_speed > MAXSP) m_speed = MAXSP;
      case (d)
        3: m_y = (m_y + m_speed > YMAX) ? YMAX : m_y + m_speed;
        2: m_y = (m_y - m_speed < 0) ? 0 : m_y - m_speed;
        1: m_x = (m_x + m_speed > XMAX) ? XMAX : m_x + m_speed;
        default: m_x = (m_x - m_speed < 0) ? 0 : m_x - m_speed;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {BTND, BTNU, BTNR, BTNL} = b;
  endtask

  task automatic do_frame();
    @(negedge clk);
    screenEnd = 1'b1;
    repeat (3) @(negedge clk);
    screenEnd = 1'b0;
    repeat (4) @(negedge clk);
    frames_sent++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_x"}, int'(sq_x), m_x);
    chk({tag, "_y"}, int'(sq_y), m_y);
    chk({tag, "_speed"}, int'(speed), m_speed);
    chk({tag, "_moving"}, int'(moving), m_moving);
  endtask

  // Settle buttons (optionally with a sub-debounce glitch), confirm no mid-frame motion, run a frame
  task automatic frame_step(input logic [3:0] b, input bit glitch, input string tag);
    set_btn(b);
    repeat (10) @(negedge clk);
    if (glitch) begin
      set_btn(b ^ 4'($urandom_range(1, 15)));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      set_btn(b);
      repeat (10) @(negedge clk);
    end
    chk({tag, "_hold_x"}, int'(sq_x), m_x);
    chk({tag, "_hold_y"}, int'(sq_y), m_y);
    do_frame();
    model_frame(b);
    check_model(tag);
  endtask

  typedef struct {
    logic [3:0] btn;
    int x; int y; int sp; int mv;
  } vec_t;
  vec_t tbl[14];

  initial begin
    logic [3:0] rb;
    int n;
    tbl[0]  = '{4'b0000, 240, 200, 1, 0};
    tbl[1]  = '{4'b0010, 241, 200, 1, 1};
    tbl[2]  = '{4'b0010, 242, 200, 1, 1};
    tbl[3]  = '{4'b0010, 243, 200, 1, 1};
    tbl[4]  = '{4'b0010, 245, 200, 2, 1};
    tbl[5]  = '{4'b0010, 247, 200, 2, 1};
    tbl[6]  = '{4'b0010, 249, 200, 2, 1};
    tbl[7]  = '{4'b1000, 249, 201, 1, 1};
    tbl[8]  = '{4'b1100, 249, 202, 1, 1};
    tbl[9]  = '{4'b0100, 249, 201, 1, 1};
    tbl[10] = '{4'b0001, 248, 201, 1, 1};
    tbl[11] = '{4'b0000, 248, 201, 1, 0};
    tbl[12] = '{4'b1111, 248, 202, 1, 1};
    tbl[13] = '{4'b0110, 248, 201, 1, 1};

    reset = 1'b1; screenEnd = 1'b0; set_btn(4'b0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_model("reset");
    chk("reset_frame_tick", int'(frame_tick), 0);

    // Idle frames: no motion, one tick per frame
    repeat (3) do_frame();
    check_model("idle3");
    chk("idle3_ticks", tick_count, 3);

    // Short glitch on right must not propagate
    @(negedge clk); BTNR = 1'b1;
    repeat (2) @(negedge clk); BTNR = 1'b0;
    for (int i = 0; i < 5; i++) frame_step(4'b0000, 1'b0, "glitch");

    for (int i = 0; i < 14; i++) begin
      set_btn(tbl[i].btn);
      repeat (10) @(negedge clk);
      do_frame();
      model_frame(tbl[i].btn);
      chk($sformatf("tbl%0d_x", i), int'(sq_x), tbl[i].x);
      chk($sformatf("tbl%0d_y", i), int'(sq_y), tbl[i].y);
      chk($sformatf("tbl%0d_speed", i), int'(speed), tbl[i].sp);
      chk($sformatf("tbl%0d_moving", i), int'(moving), tbl[i].mv);
    end

    // Up+down resolves to down; a new direction at speed 3 restarts at speed 1
    frame_step(4'b0000, 1'b0, "pre_ud");
    frame_step(4'b1100, 1'b0, "ud");
    chk("ud_y", int'(sq_y), 202);
    for (int i = 0; i < 6; i++) frame_step(4'b1000, 1'b0, "down_run");
    chk("down_run_y", int'(sq_y), 213);
    chk("down_run_speed", int'(speed), 3);
    frame_step(4'b0010, 1'b0, "switch_r");
    chk("switch_r_x", int'(sq_x), 249);
    chk("switch_r_speed", int'(speed), 1);

    // Left edge saturation
    n = 0;
    while (m_x > 0 && n < 200) begin frame_step(4'b0001, 1'b0, "left_run"); n++; end
    frame_step(4'b0010, 1'b0, "r1");
    frame_step(4'b0010, 1'b0, "r2");
    chk("r2_x", int'(sq_x), 2);
    frame_step(4'b0001, 1'b0, "l1"); chk("l1_x", int'(sq_x), 1);
    frame_step(4'b0001, 1'b0, "l2"); chk("l2_x", int'(sq_x), 0);
    frame_step(4'b0001, 1'b0, "l3"); chk("l3_x", int'(sq_x), 0);
    chk("l3_moving", int'(moving), 1);

    // Bottom edge saturation
    n = 0;
    while (m_y < YMAX && n < 200) begin frame_step(4'b1000, 1'b0, "down_edge"); n++; end
    frame_step(4'b0100, 1'b0, "u1");
    frame_step(4'b0100, 1'b0, "u2");
    chk("u2_y", int'(sq_y), 403);
    frame_step(4'b1000, 1'b0, "d1"); chk("d1_y", int'(sq_y), 404);
    frame_step(4'b1000, 1'b0, "d2"); chk("d2_y", int'(sq_y), 405);
    frame_step(4'b1000, 1'b0, "d3"); chk("d3_y", int'(sq_y), 405);

    // Randomized frames with sticky buttons and sub-threshold glitches
    rb = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) rb = 4'($urandom_range(0, 15));
      frame_step(rb, ($urandom_range(0, 1) == 1), $sformatf("rand%0d", i));
    end

    // Reset while moving at full speed with the button still held
    for (int i = 0; i < 10; i++) frame_step(4'b0010, 1'b0, "full_speed");
    chk("full_speed_speed", int'(speed), 4);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_model("midreset");
    reset = 1'b0;
    do_frame();
    model_frame(4'b0000);
    check_model("post_reset_frame");
    frame_step(4'b0010, 1'b0, "resume");
    chk("resume_x", int'(sq_x), 241);

    chk("tick_total", tick_count, frames_sent);
    chk("no_double_tick", int'(double_tick), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
